pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-address width.
REQ-002 Parameter FWD_EN, default 1: 1 enables the forwarding unit; 0 ties fwd_a_o/fwd_b_o to 2'b00.
REQ-003 Parameter HAZARD_EN, default 1: 1 enables load-use stall detection; 0 ties stall_o to 0.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-low.
REQ-006 start_i  in  1  1 = pipeline advances; 0 = all pipeline registers hold.
REQ-007 op_i  in  7  ID-stage opcode.
REQ-008 rs1_i, rs2_i, rd_i  in  REG_AW each  ID-stage register addresses.
REQ-009 br_eq_i  in  1  ID-stage branch comparator result.
REQ-010 stall_o  out  1  hold PC and IF/ID; combinational.
REQ-011 flush_o  out  1  clear IF/ID; combinational.
REQ-012 illegal_o  out  1  ID opcode not in decode table; combinational.
REQ-013 ex_alu_op_o  out  2; ex_alu_src_o  out  1  EX-stage controls.
REQ-014 fwd_a_o, fwd_b_o  out  2 each  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-015 mem_read_o, mem_write_o  out  1 each  MEM-stage controls.
REQ-016 wb_reg_write_o, wb_mem_to_reg_o  out  1 each; wb_rd_o  out  REG_AW  WB-stage controls.

Function
REQ-017 Decode (RegWrite,MemtoReg,MemRead,MemWrite,ALUOp,ALUSrc,Branch): 0110011 -> 1,0,0,0,10,0,0; 0010011 -> 1,0,0,0,00,1,0; 0000011 -> 1,1,1,0,00,1,0; 0100011 -> 0,0,0,1,01,1,0; 1100011 -> 0,0,0,0,11,0,1; 0000000 -> all 0, ALUOp 00.
REQ-018 Any other opcode: all controls 0, ALUOp 00, illegal_o=1; decode never infers latches.
REQ-019 Pipeline registers: ID/EX {controls, rs1, rs2, rd}; EX/MEM {RegWrite, MemtoReg, MemRead, MemWrite, rd}; MEM/WB {RegWrite, MemtoReg, rd}.
REQ-020 Latency: controls of an instruction in ID at edge N appear on ex_* after N, mem_* after N+1, wb_* after N+2.
REQ-021 Load-use: stall_o=1 when HAZARD_EN, start_i=1, ID/EX MemRead=1, ID/EX rd!=0, and ID/EX rd equals rs1_i or rs2_i.
REQ-022 While stall_o=1, ID/EX loads all-zero bubble (rd=0); EX/MEM and MEM/WB advance normally.
REQ-023 flush_o=1 when start_i=1, ID decode Branch=1, br_eq_i=1, and stall_o=0; stall takes priority over flush.
REQ-024 Branch in ID with br_eq_i=0 gives flush_o=0; the branch itself advances into ID/EX.
REQ-025 fwd_a_o=10 when EX/MEM RegWrite=1, EX/MEM rd!=0, EX/MEM rd==ID/EX rs1; else 01 when MEM/WB RegWrite=1, MEM/WB rd!=0, MEM/WB rd==ID/EX rs1; else 00.
REQ-026 fwd_b_o identical to REQ-025 using ID/EX rs2; EX/MEM match has priority over MEM/WB.
REQ-027 Register x0 (address 0) never causes a stall or a forward.
REQ-028 start_i=0: all three register stages hold; stall_o=0, flush_o=0; illegal_o still reflects op_i.
REQ-029 All stage outputs are register outputs except stall_o, flush_o, illegal_o and fwd_*_o.

Reset
REQ-030 rst_i=0 asynchronously clears all pipeline registers to 0, independent of clk_i.
REQ-031 During reset, every stage output is 0; stall_o/flush_o are 0 because stage state is 0.
REQ-032 Reset deasserted mid-stream: in-flight instructions are lost; the first post-reset edge with start_i=1 captures the current ID opcode.

Verification
REQ-033 R-type 0110011, rd=3, start_i=1 -> after edge 1: ex_alu_op_o=10, ex_alu_src_o=0; after edge 3: wb_reg_write_o=1, wb_rd_o=3.
REQ-034 Load 0000011 rd=5, then R-type with rs1_i=5 in ID -> stall_o=1 for one cycle; next ex_* all 0; after one more edge, fwd_a_o=01.
REQ-035 Branch 1100011 with br_eq_i=1 -> flush_o=1 that cycle; with br_eq_i=0 -> flush_o=0; ex_alu_op_o=11 after the edge either way.
REQ-036 R-type rd=7, then R-type rs1=7, rs2=7 -> fwd_a_o=fwd_b_o=10; with rd=0 instead -> both 00.
REQ-037 Opcode 1111111 -> illegal_o=1, all stage controls 0 after the edge; start_i=0 for 3 edges -> stage outputs unchanged.
REQ-038 rst_i pulsed low between edges while wb_reg_write_o=1 -> all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline control: ID decode, ID/EX -> EX/MEM -> MEM/WB control
// registers, load-use stall detection, branch flush and operand forwarding.
module pipe_ctrl #(
  parameter int REG_AW    = 5,
  parameter int FWD_EN    = 1,
  parameter int HAZARD_EN = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [6:0]        op_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              br_eq_i,
  output logic              stall_o,
  output logic              flush_o,
  output logic              illegal_o,
  output logic [1:0]        ex_alu_op_o,
  output logic              ex_alu_src_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              wb_reg_write_o,
  output logic              wb_mem_to_reg_o,
  output logic [REG_AW-1:0] wb_rd_o
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       alu_src;
  } ctrl_t;

  ctrl_t dec;
  logic  dec_branch;

  ctrl_t             idex_ctrl;
  logic [REG_AW-1:0] idex_rs1, idex_rs2, idex_rd;
  logic              exmem_reg_write, exmem_mem_to_reg, exmem_mem_read, exmem_mem_write;
  logic [REG_AW-1:0] exmem_rd;
  logic              memwb_reg_write, memwb_mem_to_reg;
  logic [REG_AW-1:0] memwb_rd;

  always_comb begin
    dec        = '0;
    dec_branch = 1'b0;
    illegal_o  = 1'b0;
    unique case (op_i)
      OP_RTYPE:  dec = '{reg_write: 1'b1, mem_to_reg: 1'b0, mem_read: 1'b0, mem_write: 1'b0, alu_op: 2'b10, alu_src: 1'b0};
      OP_ITYPE:  dec = '{reg_write: 1'b1, mem_to_reg: 1'b0, mem_read: 1'b0, mem_write: 1'b0, alu_op: 2'b00, alu_src: 1'b1};
      OP_LOAD:   dec = '{reg_write: 1'b1, mem_to_reg: 1'b1, mem_read: 1'b1, mem_write: 1'b0, alu_op: 2'b00, alu_src: 1'b1};
      OP_STORE:  dec = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_read: 1'b0, mem_write: 1'b1, alu_op: 2'b01, alu_src: 1'b1};
      OP_BRANCH: begin
        dec        = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_read: 1'b0, mem_write: 1'b0, alu_op: 2'b11, alu_src: 1'b0};
        dec_branch = 1'b1;
      end
      OP_NOP:    dec = '0;
      default:   illegal_o = 1'b1;
    endcase
  end

  // x0 is hard-wired zero, so a load targeting it can never create a hazard.
  always_comb begin
    stall_o = 1'b0;
    if (HAZARD_EN != 0 && start_i && idex_ctrl.mem_read && idex_rd != '0 &&
        (idex_rd == rs1_i || idex_rd == rs2_i))
      stall_o = 1'b1;
  end

  assign flush_o = start_i & dec_branch & br_eq_i & ~stall_o;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs)
      return 2'b10;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (FWD_EN != 0) begin
      fwd_a_o = fwd_sel(idex_rs1);
      fwd_b_o = fwd_sel(idex_rs2);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_ctrl        <= '0;
      idex_rs1         <= '0;
      idex_rs2         <= '0;
      idex_rd          <= '0;
      exmem_reg_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_rd         <= '0;
      memwb_reg_write  <= 1'b0;
      memwb_mem_to_reg <= 1'b0;
      memwb_rd         <= '0;
    end else if (start_i) begin
      if (stall_o) begin
        idex_ctrl <= '0;
        idex_rs1  <= '0;
        idex_rs2  <= '0;
        idex_rd   <= '0;
      end else begin
        idex_ctrl <= dec;
        idex_rs1  <= rs1_i;
        idex_rs2  <= rs2_i;
        idex_rd   <= rd_i;
      end
      exmem_reg_write  <= idex_ctrl.reg_write;
      exmem_mem_to_reg <= idex_ctrl.mem_to_reg;
      exmem_mem_read   <= idex_ctrl.mem_read;
      exmem_mem_write  <= idex_ctrl.mem_write;
      exmem_rd         <= idex_rd;
      memwb_reg_write  <= exmem_reg_write;
      memwb_mem_to_reg <= exmem_mem_to_reg;
      memwb_rd         <= exmem_rd;
    end
  end

  assign ex_alu_op_o     = idex_ctrl.alu_op;
  assign ex_alu_src_o    = idex_ctrl.alu_src;
  assign mem_read_o      = exmem_mem_read;
  assign mem_write_o     = exmem_mem_write;
  assign wb_reg_write_o  = memwb_reg_write;
  assign wb_mem_to_reg_o = memwb_mem_to_reg;
  assign wb_rd_o         = memwb_rd;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: instruction-record pipeline model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_pipe_ctrl;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] NP = 7'b0000000;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
  logic [6:0] op_i = '0;
  logic [4:0] rs1_i = '0, rs2_i = '0, rd_i = '0;
  logic       br_eq_i = 1'b0;
  logic       stall_o, flush_o, illegal_o, ex_alu_src_o;
  logic [1:0] ex_alu_op_o, fwd_a_o, fwd_b_o;
  logic       mem_read_o, mem_write_o, wb_reg_write_o, wb_mem_to_reg_o;
  logic [4:0] wb_rd_o;

  pipe_ctrl #(.REG_AW(5), .FWD_EN(1), .HAZARD_EN(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .br_eq_i(br_eq_i),
    .stall_o(stall_o), .flush_o(flush_o), .illegal_o(illegal_o),
    .ex_alu_op_o(ex_alu_op_o), .ex_alu_src_o(ex_alu_src_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .wb_reg_write_o(wb_reg_write_o), .wb_mem_to_reg_o(wb_mem_to_reg_o),
    .wb_rd_o(wb_rd_o)
  );

  always #5 clk_i = ~clk_i;

  int nvec = 0;
  int nerr = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode table: {reg_write, mem_to_reg, mem_read, mem_write, alu_op, alu_src, branch, illegal}
  typedef struct packed {
    logic rw, m2r, mr, mw; logic [1:0] aop; logic asrc, br, ill;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] op);
    case (op)
      R:       return '{1, 0, 0, 0, 2'b10, 0, 0, 0};
      IT:      return '{1, 0, 0, 0, 2'b00, 1, 0, 0};
      LD:      return '{1, 1, 1, 0, 2'b00, 1, 0, 0};
      ST:      return '{0, 0, 0, 1, 2'b01, 1, 0, 0};
      BR:      return '{0, 0, 0, 0, 2'b11, 0, 1, 0};
      NP:      return '0;
      default: return '{0, 0, 0, 0, 2'b00, 0, 0, 1};
    endcase
  endfunction

  // Pipeline model: each stage holds the whole instruction; a bubble is an all-zero record.
  typedef struct packed { logic [6:0] op; logic [4:0] rs1, rs2, rd; } instr_t;
  instr_t m_ex = '0, m_mem = '0, m_wb = '0;

  function automatic logic model_stall();
    return start_i && decode(m_ex.op).mr && m_ex.rd != 0 &&
           (m_ex.rd == rs1_i || m_ex.rd == rs2_i);
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (decode(m_mem.op).rw && m_mem.rd != 0 && m_mem.rd == rs) return 2'b10;
    if (decode(m_wb.op).rw && m_wb.rd != 0 && m_wb.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_ex = '0; m_mem = '0; m_wb = '0;
    end else if (start_i) begin
      logic st;
      st = model_stall();
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = st ? instr_t'('0) : instr_t'({op_i, rs1_i, rs2_i, rd_i});
    end
  end

  always @(negedge clk_i) begin
    if (chk_en && rst_i) begin
      logic st;
      st = model_stall();
      chk("stall", 16'(stall_o), 16'(st));
      chk("flush", 16'(flush_o), 16'(start_i && decode(op_i).br && br_eq_i && !st));
      chk("illegal", 16'(illegal_o), 16'(decode(op_i).ill));
      chk("ex_ctrl", {13'b0, ex_alu_op_o, ex_alu_src_o},
          {13'b0, decode(m_ex.op).aop, decode(m_ex.op).asrc});
      chk("fwd", {12'b0, fwd_a_o, fwd_b_o}, {12'b0, model_fwd(m_ex.rs1), model_fwd(m_ex.rs2)});
      chk("mem_ctrl", {14'b0, mem_read_o, mem_write_o},
          {14'b0, decode(m_mem.op).mr, decode(m_mem.op).mw});
      chk("wb_ctrl", {9'b0, wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o},
          {9'b0, decode(m_wb.op).rw, decode(m_wb.op).m2r, m_wb.rd});
    end
  end

  function automatic logic [15:0] all_outs();
    return {stall_o, flush_o, ex_alu_op_o, ex_alu_src_o, fwd_a_o, fwd_b_o,
            mem_read_o, mem_write_o, wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o[2:0]};
  endfunction

  task automatic drive(input logic st, input logic [6:0] op, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d, input logic be);
    start_i = st; op_i = op; rs1_i = a; rs2_i = b; rd_i = d; br_eq_i = be;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    nerr++;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    repeat (3) tick();
    chk("reset_state", all_outs(), 16'h0);
    rst_i = 1'b1;
    chk_en = 1'b1;

    // R-type latency
    drive(1, R, 1, 2, 3, 0); tick();
    chk("rtype_ex_op", 16'(ex_alu_op_o), 16'h2);
    chk("rtype_ex_src", 16'(ex_alu_src_o), 16'h0);
    drive(1, NP, 0, 0, 0, 0); tick(); tick();
    chk("rtype_wb_rw", 16'(wb_reg_write_o), 16'h1);
    chk("rtype_wb_rd", 16'(wb_rd_o), 16'h3);

    // Load-use
    drive(1, LD, 0, 0, 5, 0); tick();
    drive(1, R, 5, 6, 8, 0);
    @(negedge clk_i); chk("lu_stall", 16'(stall_o), 16'h1);
    tick();
    chk("lu_bubble", {13'b0, ex_alu_op_o, ex_alu_src_o}, 16'h0);
    chk("lu_mem_read", 16'(mem_read_o), 16'h1);
    @(negedge clk_i); chk("lu_stall_clear", 16'(stall_o), 16'h0);
    tick();
    chk("lu_fwd_a", 16'(fwd_a_o), 16'h1);
    chk("lu_fwd_b", 16'(fwd_b_o), 16'h0);

    // Branch taken / not taken
    drive(1, BR, 1, 2, 0, 1);
    @(negedge clk_i); chk("br_flush", 16'(flush_o), 16'h1);
    tick(); chk("br_ex_op", 16'(ex_alu_op_o), 16'h3);
    drive(1, BR, 1, 2, 0, 0);
    @(negedge clk_i); chk("br_noflush", 16'(flush_o), 16'h0);
    tick(); chk("br_nt_ex_op", 16'(ex_alu_op_o), 16'h3);

    // EX/MEM forwarding, then x0 never forwards
    drive(1, R, 0, 0, 7, 0); tick();
    drive(1, R, 7, 7, 9, 0); tick();
    chk("fwd_exmem", {14'b0, fwd_a_o, fwd_b_o}, 16'b1010);
    drive(1, R, 0, 0, 0, 0); tick();
    drive(1, R, 0, 0, 9, 0); tick();
    chk("fwd_x0", {14'b0, fwd_a_o, fwd_b_o}, 16'h0);

    // Illegal opcode, then freeze for three edges
    drive(1, BAD, 1, 2, 3, 0);
    @(negedge clk_i); chk("illegal", 16'(illegal_o), 16'h1);
    tick(); chk("illegal_ex", {13'b0, ex_alu_op_o, ex_alu_src_o}, 16'h0);
    drive(0, BR, 9, 9, 4, 1);
    repeat (3) tick();
    chk("hold_wb", {10'b0, wb_reg_write_o, wb_rd_o}, 16'h20);
    chk("hold_mem", {14'b0, mem_read_o, mem_write_o}, 16'h0);
    @(negedge clk_i); chk("hold_flush", 16'(flush_o), 16'h0);

    // Asynchronous reset pulse between edges while wb_reg_write_o=1
    drive(0, NP, 0, 0, 0, 0);
    tick();
    #2 rst_i = 1'b0;
    #1 chk("async_reset", all_outs(), 16'h0);
    rst_i = 1'b1;

    // Post-reset: I-type, then store forwarding from it, then mem_write
    drive(1, IT, 0, 0, 4, 0); tick();
    chk("itype_ex", {13'b0, ex_alu_op_o, ex_alu_src_o}, 16'h1);
    chk("post_reset_wb", {10'b0, wb_reg_write_o, wb_rd_o}, 16'h0);
    drive(1, ST, 4, 0, 0, 0); tick();
    chk("st_fwd_a", 16'(fwd_a_o), 16'h2);
    drive(1, NP, 0, 0, 0, 0); tick();
    chk("st_mem_write", 16'(mem_write_o), 16'h1);

    // Load to x0 never stalls
    drive(1, LD, 0, 0, 0, 0); tick();
    drive(1, R, 0, 0, 1, 0);
    @(negedge clk_i); chk("x0_nostall", 16'(stall_o), 16'h0);
    tick();
    drive(1, NP, 0, 0, 0, 0);
    repeat (4) tick();

    @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
